// File: rtl/sraml_axi_pkg.sv
// Shared types and constants for the sram_like to AXI bridges.
package sraml_axi_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW_W,
        S_B,
        S_DONE
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/sraml_strb_gen.sv
// Byte-strobe generator: transfer size and low address bits to AXI wstrb.
module sraml_strb_gen
    import sraml_axi_pkg::*;
(
    input  logic [1:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strb
);

    // Size 3 is not a legal sram_like size and falls back to a full word.
    always_comb begin
        strb = 4'b1111;
        unique case (1'b1)
            (size == SIZE_BYTE): strb = 4'b0001 << addr_lo;
            (size == SIZE_HALF): strb = 4'b0011 << {addr_lo[1], 1'b0};
            default:             strb = 4'b1111;
        endcase
    end

endmodule

// File: rtl/d_sraml2axi.sv
// Data-side sram_like to single-beat AXI bridge, one transaction at a time.
// Define SRAML_RESP_ERR_EN to add the data_err response-error output.
module d_sraml2axi
    import sraml_axi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
`ifdef SRAML_RESP_ERR_EN
    output logic        data_err,
`endif
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    state_t      state_q;
    state_t      state_d;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic [3:0]  strb_in;
    logic [31:0] rdata_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        aw_fin;
    logic        w_fin;

    sraml_strb_gen u_strb (
        .size    (data_size),
        .addr_lo (data_addr[1:0]),
        .strb    (strb_in)
    );

    assign aw_fin = aw_done_q | awready;
    assign w_fin  = w_done_q | wready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (data_req) state_d = data_wr ? S_AW_W : S_AR;
            S_AR:   if (arready) state_d = S_R;
            S_R:    if (rvalid) state_d = S_DONE;
            S_AW_W: if (aw_fin && w_fin) state_d = S_B;
            S_B:    if (bvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request fields are captured once at accept and held until DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= 32'b0;
            size_q    <= 2'b0;
            wdata_q   <= 32'b0;
            strb_q    <= 4'b0;
            rdata_q   <= 32'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (state_q == S_IDLE && data_req) begin
                addr_q    <= data_addr;
                size_q    <= data_size;
                wdata_q   <= data_wdata;
                strb_q    <= strb_in;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == S_AW_W) begin
                if (awready) aw_done_q <= 1'b1;
                if (wready)  w_done_q  <= 1'b1;
            end
            if (state_q == S_R && rvalid) rdata_q <= rdata;
        end
    end

`ifdef SRAML_RESP_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == S_R && rvalid) begin
            err_q <= (rresp != AXI_RESP_OKAY);
        end else if (state_q == S_B && bvalid) begin
            err_q <= (bresp != AXI_RESP_OKAY);
        end
    end

    assign data_err = (state_q == S_DONE) && err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};
`endif

    assign data_addr_ok = (state_q == S_IDLE) && data_req;
    assign data_data_ok = (state_q == S_DONE);
    assign data_rdata   = rdata_q;

    assign araddr  = addr_q;
    assign arsize  = {1'b0, size_q};
    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);

    assign awaddr  = addr_q;
    assign awsize  = {1'b0, size_q};
    assign awvalid = (state_q == S_AW_W) && !aw_done_q;
    assign wdata   = wdata_q;
    assign wstrb   = strb_q;
    assign wvalid  = (state_q == S_AW_W) && !w_done_q;
    assign bready  = (state_q == S_B);

endmodule

// File: tb/tb_d_sraml2axi.sv
// Directed self-checking bench for d_sraml2axi.
module tb_d_sraml2axi;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
`ifdef SRAML_RESP_ERR_EN
    logic        data_err;
`endif
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    d_sraml2axi dut (
        .clk          (clk),
        .rst          (rst),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
`ifdef SRAML_RESP_ERR_EN
        .data_err     (data_err),
`endif
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Concatenation of all valid/ready/ok outputs, LSB first:
    // addr_ok, data_ok, arvalid, rready, awvalid, wvalid, bready
    function automatic logic [31:0] hs();
        return {25'b0, bready, wvalid, awvalid, rready, arvalid,
                data_data_ok, data_addr_ok};
    endfunction

    initial begin
        rst = 1'b1;
        data_req = 0; data_wr = 0; data_size = 0;
        data_addr = 0; data_wdata = 0;
        arready = 0; rdata = 0; rresp = 0; rvalid = 0;
        awready = 0; wready = 0; bresp = 0; bvalid = 0;
        tick();
        tick();

        // Reset state
        chk("rst_hs", hs(), 32'h0);
        chk("rst_rdata", data_rdata, 32'h0);
        chk("rst_wstrb", {28'b0, wstrb}, 32'h0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_awaddr", awaddr, 32'h0);
        chk("rst_wdata", wdata, 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait word read
        data_req = 1; data_wr = 0; data_size = 2;
        data_addr = 32'h1000_0004;
        #1;
        chk("rd_addr_ok_c0", hs(), 32'h01);
        tick();
        data_req = 0;
        chk("rd_arvalid_c1", hs(), 32'h04);
        chk("rd_araddr", araddr, 32'h1000_0004);
        chk("rd_arsize", {29'b0, arsize}, 32'h2);
        arready = 1;
        tick();
        arready = 0;
        chk("rd_rready_c2", hs(), 32'h08);
        rvalid = 1; rdata = 32'hDEAD_BEEF;
        tick();
        rvalid = 0; rdata = 32'h0;
        chk("rd_data_ok_c3", hs(), 32'h02);
        chk("rd_rdata", data_rdata, 32'hDEAD_BEEF);
        tick();
        chk("rd_idle", hs(), 32'h0);
        chk("rd_rdata_held", data_rdata, 32'hDEAD_BEEF);

        // Byte write, wready two cycles after awready
        data_req = 1; data_wr = 1; data_size = 0;
        data_addr = 32'h2000_0003; data_wdata = 32'hAB00_0000;
        #1;
        chk("bw_addr_ok", hs(), 32'h01);
        tick();
        data_req = 0; data_wdata = 32'h0;
        chk("bw_aw_w", hs(), 32'h30);
        chk("bw_wstrb", {28'b0, wstrb}, 32'h8);
        chk("bw_awsize", {29'b0, awsize}, 32'h0);
        chk("bw_awaddr", awaddr, 32'h2000_0003);
        chk("bw_wdata", wdata, 32'hAB00_0000);
        awready = 1;
        tick();
        awready = 0;
        chk("bw_w_only_1", hs(), 32'h20);
        tick();
        chk("bw_w_only_2", hs(), 32'h20);
        chk("bw_wdata_stable", wdata, 32'hAB00_0000);
        wready = 1;
        tick();
        wready = 0;
        chk("bw_bready", hs(), 32'h40);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("bw_data_ok", hs(), 32'h02);
        tick();
        chk("bw_single_ok", hs(), 32'h0);

        // Half write at addr[1:0] = 2, AW and W in the same cycle
        data_req = 1; data_wr = 1; data_size = 1;
        data_addr = 32'h3000_0006; data_wdata = 32'h1234_0000;
        tick();
        data_req = 0;
        chk("hw_wstrb", {28'b0, wstrb}, 32'hC);
        chk("hw_awsize", {29'b0, awsize}, 32'h1);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        chk("hw_straight_b", hs(), 32'h40);
        bvalid = 1;
        tick();
        bvalid = 0;
        chk("hw_data_ok", hs(), 32'h02);
        tick();

        // Back-to-back reads with req held high
        data_req = 1; data_wr = 0; data_size = 2;
        data_addr = 32'h4000_0000;
        #1;
        chk("bb_addr_ok_1", hs(), 32'h01);
        tick();
        chk("bb_ar_no_ok", hs(), 32'h04);
        arready = 1;
        tick();
        arready = 0;
        chk("bb_r_no_ok", hs(), 32'h08);
        rvalid = 1; rdata = 32'h1111_2222;
        tick();
        rvalid = 0;
        chk("bb_done_no_addr_ok", hs(), 32'h02);
        tick();
        chk("bb_addr_ok_2", hs(), 32'h01);
        tick();
        data_req = 0;
        chk("bb_ar_2", hs(), 32'h04);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h3333_4444;
        tick();
        rvalid = 0;
        chk("bb_rdata_2", data_rdata, 32'h3333_4444);
        tick();

        // Reset while waiting in R
        data_req = 1; data_wr = 0; data_size = 2;
        data_addr = 32'h5000_0008;
        tick();
        data_req = 0;
        arready = 1;
        tick();
        arready = 0;
        chk("mr_in_r", hs(), 32'h08);
        rst = 1;
        tick();
        rst = 0;
        chk("mr_after_rst", hs(), 32'h0);
        chk("mr_rdata_cleared", data_rdata, 32'h0);
        data_req = 1; data_addr = 32'h6000_0000;
        #1;
        chk("mr_idle_accept", hs(), 32'h01);
        tick();
        data_req = 0;
        chk("mr_araddr", araddr, 32'h6000_0000);
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h55AA_55AA;
        tick();
        rvalid = 0;
        chk("mr_done", hs(), 32'h02);
        chk("mr_rdata", data_rdata, 32'h55AA_55AA);
        tick();

        // Error response read, then OKAY write
        data_req = 1; data_wr = 0; data_size = 2;
        data_addr = 32'h7000_0000;
        tick();
        data_req = 0;
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rresp = 2'b10; rdata = 32'h0BAD_0BAD;
        tick();
        rvalid = 0; rresp = 2'b00;
        chk("er_rd_done", hs(), 32'h02);
`ifdef SRAML_RESP_ERR_EN
        chk("er_rd_err", {31'b0, data_err}, 32'h1);
`endif
        tick();
        data_req = 1; data_wr = 1; data_size = 2;
        data_addr = 32'h7000_0010; data_wdata = 32'hCAFE_F00D;
        tick();
        data_req = 0;
        chk("er_wstrb_word", {28'b0, wstrb}, 32'hF);
        awready = 1; wready = 1;
        tick();
        awready = 0; wready = 0;
        bvalid = 1; bresp = 2'b00;
        tick();
        bvalid = 0;
        chk("er_wr_done", hs(), 32'h02);
`ifdef SRAML_RESP_ERR_EN
        chk("er_wr_err", {31'b0, data_err}, 32'h0);
`endif
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
